cbus_arbiter: RTL and testbench

// - N-to-1 arbiter for the cache-line bus (CBus). Sits directly downstream of the

---
 rtl/cbus_arbiter_if.sv | 47 ++++
 rtl/cbus_arbiter.sv | 127 ++++++++++++
 tb/tb_cbus_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// CBus request/response types and the arbiter's bus bundle.
// master = requesters + memory side, slave = the arbiter itself.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

endinterface

// File: rtl/cbus_arbiter.sv
// N-to-1 CBus arbiter holding a grant for a whole (burst) transaction.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module cbus_arbiter #(
  parameter int NUM_INPUTS = 2
) (
  input logic         clk,
  input logic         reset,
  cbus_arbiter_if.slave bus
);
  import cbus_pkg::*;

  localparam int SEL_W =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] base;
  logic             any_valid;
  logic             done;
  logic             sel_valid;
  logic [NUM_INPUTS-1:0] rdy_vec;

  assign done = bus.oresp.ready
              & bus.oresp.last;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q;

  assign base = ptr_q;

  // Pointer moves past the winner on each completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (state_q == BUSY && done) begin
      if (sel_q == SEL_W'(NUM_INPUTS - 1))
        ptr_q <= '0;
      else
        ptr_q <= sel_q + 1'b1;
    end
  end
`else
  assign base = '0;
`endif

  // First valid index at or after base, wrapping around.
  always_comb begin
    int j;
    j         = 0;
    pick      = '0;
    any_valid = 1'b0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      j = (int'(base) + k) % NUM_INPUTS;
      if (bus.ireqs[j].valid) begin
        pick      = SEL_W'(j);
        any_valid = 1'b1;
      end
    end
  end

  // State and grant index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next state plus live forwarding of the granted port.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    bus.oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      bus.iresps[i] = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          sel_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.oreq          = bus.ireqs[sel_q];
        bus.iresps[sel_q] = bus.oresp;
        if (done)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Observation taps used by the checks below.
  always_comb begin
    sel_valid = bus.ireqs[sel_q].valid;
    for (int i = 0; i < NUM_INPUTS; i++)
      rdy_vec[i] = bus.iresps[i].ready;
  end

`ifndef SYNTHESIS
  // Requester must hold valid until ready&last.
  a_hold_valid: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == BUSY) |-> sel_valid
  ) else $error("cbus_arbiter: valid dropped while BUSY");

  // Never two requesters handshaking at once.
  a_one_ready: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(rdy_vec)
  ) else $error("cbus_arbiter: multiple iresps ready");
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed and random bench for cbus_arbiter.
// Expectations follow CBUS_ARB_ROUND_ROBIN_EN if defined.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_INPUTS(2)) bus ();

  cbus_arbiter #(.NUM_INPUTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ireqs[0] = '0;
    bus.ireqs[1] = '0;
    bus.oresp    = '0;
  endtask

  function automatic cbus_req_t mk_req(
    input logic        v,
    input logic        w,
    input logic [31:0] a,
    input logic [3:0]  s,
    input logic [31:0] d,
    input logic [3:0]  l
  );
    cbus_req_t r;
    r          = '0;
    r.valid    = v;
    r.is_write = w;
    r.size     = 3'd2;
    r.addr     = a;
    r.strobe   = s;
    r.data     = d;
    r.len      = l;
    return r;
  endfunction

  function automatic cbus_resp_t mk_rsp(
    input logic        rd,
    input logic        ls,
    input logic [31:0] d
  );
    cbus_resp_t r;
    r.ready = rd;
    r.last  = ls;
    r.data  = d;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.ireqs[0] = mk_req(1, 0, 32'h100, 4'hf, 0, 0);
    bus.oresp    = mk_rsp(1, 1, 32'h1);
    tick();
    tick();
    settle();
    vectors++;
    if (bus.oreq !== '0) begin
      miscompares++;
      $display("FAIL reset_oreq: got %h want 0", bus.oreq);
    end
    vectors++;
    if (bus.iresps[0] !== '0 || bus.iresps[1] !== '0) begin
      miscompares++;
      $display("FAIL reset_iresps: got %h %h want 0 0",
               bus.iresps[0], bus.iresps[1]);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    cbus_req_t  r0;
    cbus_resp_t rs;
    r0 = mk_req(1, 0, 32'h100, 4'hf, 0, 0);
    tick();
    bus.ireqs[0] = r0;
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: got %b want 0", bus.oreq.valid);
    end
    tick();
    settle();
    vectors++;
    if (bus.oreq !== r0) begin
      miscompares++;
      $display("FAIL single_fwd: got %h want %h", bus.oreq, r0);
    end
    rs = mk_rsp(1, 1, 32'hdead_beef);
    bus.oresp = rs;
    settle();
    vectors++;
    if (bus.iresps[0] !== rs) begin
      miscompares++;
      $display("FAIL single_resp0: got %h want %h", bus.iresps[0], rs);
    end
    vectors++;
    if (bus.iresps[1] !== '0) begin
      miscompares++;
      $display("FAIL single_resp1: got %h want 0", bus.iresps[1]);
    end
    tick();
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got %b want 0", bus.oreq.valid);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    cbus_req_t ra;
    cbus_req_t rb;
    cbus_req_t rq [2];
    int first;
    int second;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    first = 1;
`else
    first = 0;
`endif
    second = 1 - first;
    ra = mk_req(1, 0, 32'h200, 4'hf, 0, 0);
    rb = mk_req(1, 1, 32'h300, 4'h3, 32'h1234_5678, 0);
    rq[0] = ra;
    rq[1] = rb;
    tick();
    bus.ireqs[0] = ra;
    bus.ireqs[1] = rb;
    tick();
    settle();
    vectors++;
    if (bus.oreq !== rq[first]) begin
      miscompares++;
      $display("FAIL prio_first: got %h want %h", bus.oreq, rq[first]);
    end
    bus.oresp = mk_rsp(1, 1, 32'h11);
    settle();
    vectors++;
    if (bus.iresps[first].ready !== 1'b1 ||
        bus.iresps[second] !== '0) begin
      miscompares++;
      $display("FAIL prio_resp1: got %b/%h want 1/0",
               bus.iresps[first].ready, bus.iresps[second]);
    end
    tick();
    bus.ireqs[first] = '0;
    bus.oresp = '0;
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_gap: got %b want 0", bus.oreq.valid);
    end
    tick();
    settle();
    vectors++;
    if (bus.oreq !== rq[second]) begin
      miscompares++;
      $display("FAIL prio_second: got %h want %h", bus.oreq, rq[second]);
    end
    bus.oresp = mk_rsp(1, 1, 32'h22);
    settle();
    vectors++;
    if (bus.iresps[second].ready !== 1'b1 ||
        bus.iresps[first] !== '0) begin
      miscompares++;
      $display("FAIL prio_resp2: got %b/%h want 1/0",
               bus.iresps[second].ready, bus.iresps[first]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_burst();
    cbus_req_t   ric;
    logic        rdy;
    logic [31:0] wdat;
    logic [3:0]  wstb;
    int beat;
    int cyc;
    ric = mk_req(1, 0, 32'h500, 4'hf, 0, 0);
    tick();
    bus.ireqs[1] = mk_req(1, 1, 32'h400, 4'h5, 32'hb000_0000, 15);
    tick();
    bus.ireqs[0] = ric;
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 200) begin
      wdat = 32'hb000_0000 | 32'(beat);
      wstb = 4'(beat) ^ 4'h5;
      bus.ireqs[1].data   = wdat;
      bus.ireqs[1].strobe = wstb;
      rdy = ($urandom_range(0, 2) != 0);
      bus.oresp = mk_rsp(rdy, rdy && beat == 15, 0);
      settle();
      vectors++;
      if (bus.oreq.valid !== 1'b1 || bus.oreq.addr !== 32'h400 ||
          bus.oreq.data !== wdat || bus.oreq.strobe !== wstb) begin
        miscompares++;
        $display("FAIL burst_beat%0d: got %h want addr 400 data %h stb %h",
                 beat, bus.oreq, wdat, wstb);
      end
      vectors++;
      if (bus.iresps[0].ready !== 1'b0 ||
          bus.iresps[1].ready !== rdy) begin
        miscompares++;
        $display("FAIL burst_ready%0d: got %b%b want 0%b", beat,
                 bus.iresps[0].ready, bus.iresps[1].ready, rdy);
      end
      tick();
      if (rdy) beat++;
      cyc++;
    end
    vectors++;
    if (beat != 16) begin
      miscompares++;
      $display("FAIL burst_timeout: got %0d beats want 16", beat);
    end
    bus.ireqs[1] = '0;
    bus.oresp = '0;
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_gap: got %b want 0", bus.oreq.valid);
    end
    tick();
    settle();
    vectors++;
    if (bus.oreq !== ric) begin
      miscompares++;
      $display("FAIL burst_next: got %h want %h", bus.oreq, ric);
    end
    bus.oresp = mk_rsp(1, 1, 0);
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    cbus_req_t rf;
    rf = mk_req(1, 0, 32'h700, 4'hf, 0, 0);
    tick();
    bus.ireqs[1] = mk_req(1, 1, 32'h600, 4'hf, 32'h66, 15);
    tick();
    for (int b = 0; b < 5; b++) begin
      bus.oresp = mk_rsp(1, 0, 0);
      tick();
    end
    bus.oresp = '0;
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstbusy_pre: got %b want 1", bus.oreq.valid);
    end
    reset = 1'b1;
    tick();
    bus.oresp = mk_rsp(1, 0, 32'h77);
    settle();
    vectors++;
    if (bus.oreq.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstbusy_oreq: got %b want 0", bus.oreq.valid);
    end
    vectors++;
    if (bus.iresps[0] !== '0 || bus.iresps[1] !== '0) begin
      miscompares++;
      $display("FAIL rstbusy_iresps: got %h %h want 0 0",
               bus.iresps[0], bus.iresps[1]);
    end
    reset = 1'b0;
    idle_inputs();
    bus.ireqs[0] = rf;
    tick();
    settle();
    vectors++;
    if (bus.oreq !== rf) begin
      miscompares++;
      $display("FAIL rstbusy_fresh: got %h want %h", bus.oreq, rf);
    end
    bus.oresp = mk_rsp(1, 1, 0);
    tick();
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [1:0]  want;
    logic [1:0]  got;
    logic [31:0] wadr;
    int exp;
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    bus.ireqs[0] = mk_req(1, 0, 32'h800, 4'hf, 0, 0);
    bus.ireqs[1] = mk_req(1, 0, 32'h900, 4'hf, 0, 0);
    for (int t = 0; t < 8; t++) begin
      tick();
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      exp = t % 2;
`else
      exp = 0;
`endif
      bus.oresp = mk_rsp(1, 1, 32'(t));
      settle();
      want = 2'b01 << exp;
      got  = {bus.iresps[1].ready, bus.iresps[0].ready};
      wadr = (exp == 1) ? 32'h900 : 32'h800;
      vectors++;
      if (got !== want || bus.oreq.addr !== wadr) begin
        miscompares++;
        $display("FAIL fair_txn%0d: got rdy %b addr %h want %b %h",
                 t, got, bus.oreq.addr, want, wadr);
      end
      tick();
      bus.oresp = '0;
      settle();
      vectors++;
      if (bus.oreq.valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fair_gap%0d: got %b want 0", t, bus.oreq.valid);
      end
    end
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] mem  [16];
    logic [31:0] refm [16];
    logic        act  [2];
    logic        wr   [2];
    logic [3:0]  bas  [2];
    logic [3:0]  len  [2];
    logic [3:0]  bt   [2];
    logic [31:0] wd   [2];
    int          dn   [2];
    logic [3:0]  mbeat;
    logic [3:0]  a;
    cbus_req_t   rq;
    cbus_resp_t  rs;
    for (int k = 0; k < 16; k++) begin
      mem[k]  = 32'h5a5a_0000 | 32'(k);
      refm[k] = 32'h5a5a_0000 | 32'(k);
    end
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      wr[i]  = 1'b0;
      bas[i] = '0;
      len[i] = '0;
      bt[i]  = '0;
      wd[i]  = '0;
      dn[i]  = 0;
    end
    mbeat = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1'b1;
          wr[i]  = 1'($urandom_range(0, 1));
          bas[i] = 4'($urandom_range(0, 15));
          len[i] = 4'($urandom_range(0, 3));
          bt[i]  = '0;
        end
        wd[i] = $urandom;
        rq = mk_req(act[i], wr[i], {26'b0, bas[i], 2'b00},
                    4'hf, wd[i], len[i]);
        bus.ireqs[i] = rq;
      end
      settle();
      rs = '0;
      if (bus.oreq.valid) begin
        a = bus.oreq.addr[5:2] + mbeat;
        rs.ready = ($urandom_range(0, 3) != 0);
        rs.last  = rs.ready && (mbeat == bus.oreq.len);
        if (rs.ready) begin
          if (bus.oreq.is_write) mem[a] = bus.oreq.data;
          else rs.data = mem[a];
          mbeat = rs.last ? 4'd0 : mbeat + 4'd1;
        end
      end
      bus.oresp = rs;
      settle();
      vectors++;
      if (bus.iresps[0].ready && bus.iresps[1].ready) begin
        miscompares++;
        $display("FAIL rand_two_ready: cycle %0d got 11 want <=1", c);
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.iresps[i].ready) begin
          a = bas[i] + bt[i];
          vectors++;
          if (bus.iresps[i].last !== (bt[i] == len[i])) begin
            miscompares++;
            $display("FAIL rand_last%0d: cycle %0d got %b want %b", i, c,
                     bus.iresps[i].last, bt[i] == len[i]);
          end
          if (wr[i]) begin
            refm[a] = wd[i];
          end else begin
            vectors++;
            if (bus.iresps[i].data !== refm[a]) begin
              miscompares++;
              $display("FAIL rand_rdata%0d: cycle %0d got %h want %h", i, c,
                       bus.iresps[i].data, refm[a]);
            end
          end
          if (bt[i] == len[i]) begin
            act[i] = 1'b0;
            dn[i]++;
          end else begin
            bt[i] = bt[i] + 4'd1;
          end
        end
      end
      tick();
    end
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (dn[i] == 0) begin
        miscompares++;
        $display("FAIL rand_progress%0d: got 0 txns want >0", i);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_burst();
    test_reset_busy();
    test_fairness();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
